// File: rtl/warp_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : warp_sched_pkg
//  Description : Shared types and constants for the warp scheduler slice:
//                push-sequencer state encoding and arbitration-mode codes.
//  Revision    : 1.0  initial release
// ============================================================================
package warp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PUSH      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational find-first arbiter. In round-robin mode the
//                search starts at ptr and wraps modulo N; in fixed mode it
//                starts at index 0 and ptr is ignored.
//  Ports       : req[N]        request vector
//                ptr           round-robin start index (0..N-1)
//                mode          0 = round-robin, 1 = fixed (lowest wins)
//                gnt_valid     any request present
//                gnt_id        granted index, 0 when gnt_valid = 0
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import warp_sched_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            mode,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] w_base;
    logic [ID_W:0]   w_sum;

    assign w_base = (mode == 1'(ARB_FIXED)) ? '0 : ptr;

    // Walk the N candidates starting at w_base; one extra bit on the sum lets
    // the wrap be done by a single conditional subtract for any N.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        w_sum     = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, w_base} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N)) begin
                w_sum = w_sum - (ID_W+1)'(N);
            end
            if (!gnt_valid && req[w_sum[ID_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_id    = w_sum[ID_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/warp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : warp_scheduler
//  Description : Per-cycle warp selection for instruction issue (round-robin
//                or fixed priority) plus sequencing of the warps that feed
//                the systolic array during a matmul push.
//  Ports       : clk, reset_n      clock, async active-low reset
//                ready_warps       per-warp ready from the warp-state table
//                push_en/push_mask push start and participating warps
//                matmul_done       push/pull unit reports completion
//                instr_ready       issue stage accepts instr_warp
//                push_valid/warp   warp pushed this cycle
//                pause             required push warp not ready
//                push_active       push sequence in progress
//                instr_valid/warp  instruction grant
//                stall_cnt         saturating pause count of current/last push
//  Revision    : 1.0  initial release
// ============================================================================
module warp_scheduler
    import warp_sched_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int WID_W     = $clog2(NUM_WARPS),
    parameter int ARB_MODE  = 0,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_WARPS-1:0] ready_warps,
    input  logic                 push_en,
    input  logic [NUM_WARPS-1:0] push_mask,
    input  logic                 matmul_done,
    input  logic                 instr_ready,
    output logic                 push_valid,
    output logic [WID_W-1:0]     push_warp,
    output logic                 pause,
    output logic                 push_active,
    output logic                 instr_valid,
    output logic [WID_W-1:0]     instr_warp,
    output logic [CNT_W-1:0]     stall_cnt
);

    state_t                r_state;
    logic [WID_W-1:0]      r_cur;
    logic [WID_W-1:0]      r_rr_ptr;
    logic [NUM_WARPS-1:0]  r_pmask;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic                  w_in_push;
    logic                  w_cur_ready;
    logic [NUM_WARPS-1:0]  w_above;
    logic [NUM_WARPS-1:0]  w_srch_req;
    logic                  w_srch_valid;
    logic [WID_W-1:0]      w_srch_id;
    logic [NUM_WARPS-1:0]  w_push_onehot;
    logic [NUM_WARPS-1:0]  w_eligible;

    assign w_in_push   = (r_state == PUSH);
    assign w_cur_ready = ready_warps[r_cur];

    assign push_valid  = w_in_push &  w_cur_ready;
    assign pause       = w_in_push & ~w_cur_ready;
    assign push_warp   = push_valid ? r_cur : '0;
    assign push_active = (r_state != IDLE);
    assign stall_cnt   = r_stall_cnt;

    // Bits strictly above the current push warp.
    always_comb begin
        w_above = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_above[i] = (i > int'(r_cur));
        end
    end

    // One lowest-set-bit search serves both the start of a push (over the
    // incoming mask) and the advance to the next participant (over the
    // latched mask restricted to bits above cur).
    assign w_srch_req = (r_state == IDLE) ? push_mask : (r_pmask & w_above);

    rr_arbiter #(
        .N    (NUM_WARPS)
    ) u_mask_search (
        .req       (w_srch_req),
        .ptr       ('0),
        .mode      (1'b1),
        .gnt_valid (w_srch_valid),
        .gnt_id    (w_srch_id)
    );

    // A warp being pushed this cycle cannot also issue.
    assign w_push_onehot = push_valid ? (NUM_WARPS'(1) << r_cur) : '0;
    assign w_eligible    = ready_warps & ~w_push_onehot;

    rr_arbiter #(
        .N    (NUM_WARPS)
    ) u_instr_arb (
        .req       (w_eligible),
        .ptr       (r_rr_ptr),
        .mode      (ARB_MODE == ARB_FIXED),
        .gnt_valid (instr_valid),
        .gnt_id    (instr_warp)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cur       <= '0;
            r_pmask     <= '0;
            r_rr_ptr    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (instr_valid && instr_ready) begin
                r_rr_ptr <= (instr_warp == WID_W'(NUM_WARPS-1)) ? '0
                                                                : instr_warp + WID_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (push_en && (|push_mask)) begin
                        r_pmask     <= push_mask;
                        r_cur       <= w_srch_id;
                        r_stall_cnt <= '0;
                        r_state     <= PUSH;
                    end
                end
                PUSH: begin
                    // Every pause cycle counts, even one that coincides with
                    // matmul_done.
                    if (pause && (r_stall_cnt != '1)) begin
                        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                    end
                    if (matmul_done) begin
                        r_state <= IDLE;
                    end else if (push_valid) begin
                        if (w_srch_valid) begin
                            r_cur <= w_srch_id;
                        end else begin
                            r_state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (matmul_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_warp_scheduler
//  Description : Self-checking bench for warp_scheduler. Two instances share
//                stimulus: one round-robin, one fixed priority.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_warp_scheduler;
    import warp_sched_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] ready_warps = '0;
    logic       push_en = 1'b0;
    logic [3:0] push_mask = '0;
    logic       matmul_done = 1'b0;
    logic       instr_ready = 1'b0;

    logic       pv_a, pause_a, pa_a, iv_a;
    logic [1:0] pw_a, iw_a;
    logic [7:0] sc_a;
    logic       pv_b, pause_b, pa_b, iv_b;
    logic [1:0] pw_b, iw_b;
    logic [7:0] sc_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    warp_scheduler #(.NUM_WARPS(4), .ARB_MODE(ARB_RR), .CNT_W(8)) dut_rr (
        .clk(clk), .reset_n(reset_n), .ready_warps(ready_warps),
        .push_en(push_en), .push_mask(push_mask), .matmul_done(matmul_done),
        .instr_ready(instr_ready), .push_valid(pv_a), .push_warp(pw_a),
        .pause(pause_a), .push_active(pa_a), .instr_valid(iv_a),
        .instr_warp(iw_a), .stall_cnt(sc_a)
    );

    warp_scheduler #(.NUM_WARPS(4), .ARB_MODE(ARB_FIXED), .CNT_W(8)) dut_fx (
        .clk(clk), .reset_n(reset_n), .ready_warps(ready_warps),
        .push_en(push_en), .push_mask(push_mask), .matmul_done(matmul_done),
        .instr_ready(instr_ready), .push_valid(pv_b), .push_warp(pw_b),
        .pause(pause_b), .push_active(pa_b), .instr_valid(iv_b),
        .instr_warp(iw_b), .stall_cnt(sc_b)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] rdy;
        logic       pen;
        logic [3:0] pm;
        logic       done;
        logic       ir;
        logic       e_pv;
        logic [1:0] e_pw;
        logic       e_pause;
        logic       e_pa;
        logic       e_iv;
        logic [1:0] e_iw;
        logic [1:0] e_fiw;
        logic [7:0] e_sc;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t mkv(input logic r, input logic [3:0] rd, input logic pe,
                                 input logic [3:0] pm, input logic d, input logic i,
                                 input logic pv, input logic [1:0] pw, input logic ps,
                                 input logic pa, input logic iv, input logic [1:0] iw,
                                 input logic [1:0] fiw, input logic [7:0] sc);
        vec_t v;
        v.rst_n = r;  v.rdy = rd;  v.pen = pe;  v.pm = pm;  v.done = d;  v.ir = i;
        v.e_pv = pv;  v.e_pw = pw; v.e_pause = ps; v.e_pa = pa;
        v.e_iv = iv;  v.e_iw = iw; v.e_fiw = fiw; v.e_sc = sc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rd, input logic pe,
                         input logic [3:0] pm, input logic d, input logic i);
        reset_n     = r;
        ready_warps = rd;
        push_en     = pe;
        push_mask   = pm;
        matmul_done = d;
        instr_ready = i;
    endtask

    // First index at or after start (wrapping) whose bit is set; -1 if none.
    function automatic int first_from(input logic [3:0] el, input int start);
        for (int k = 0; k < 4; k++) begin
            if (el[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    // Reference model state: queue of warps still to push in this sequence.
    int  mq[$];
    bit  m_act;
    int  m_stall;
    int  m_rr;

    initial begin
        // rst rdy pen pm done ir | pv pw pause pa iv iw fiw stall
        tbl[0]  = mkv(0, 4'hF, 0, 4'h0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mkv(1, 4'hF, 0, 4'h0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mkv(1, 4'hF, 0, 4'h0, 0, 1,  0, 0, 0, 0, 1, 1, 0, 0);
        tbl[3]  = mkv(1, 4'hF, 0, 4'h0, 0, 1,  0, 0, 0, 0, 1, 2, 0, 0);
        tbl[4]  = mkv(1, 4'hF, 0, 4'h0, 0, 1,  0, 0, 0, 0, 1, 3, 0, 0);
        tbl[5]  = mkv(1, 4'hF, 0, 4'h0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0);
        // push mask 1011, all ready
        tbl[6]  = mkv(1, 4'hF, 1, 4'hB, 0, 1,  0, 0, 0, 0, 1, 1, 0, 0);
        tbl[7]  = mkv(1, 4'hF, 0, 4'h0, 0, 1,  1, 0, 0, 1, 1, 2, 1, 0);
        tbl[8]  = mkv(1, 4'hF, 0, 4'h0, 0, 1,  1, 1, 0, 1, 1, 3, 0, 0);
        tbl[9]  = mkv(1, 4'hF, 0, 4'h0, 0, 1,  1, 3, 0, 1, 1, 0, 0, 0);
        tbl[10] = mkv(1, 4'hF, 0, 4'h0, 1, 1,  0, 0, 0, 1, 1, 1, 0, 0);
        tbl[11] = mkv(1, 4'hF, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 2, 0, 0);
        // push mask 1111, warp 2 not ready for 3 cycles
        tbl[12] = mkv(1, 4'hF, 1, 4'hF, 0, 0,  0, 0, 0, 0, 1, 2, 0, 0);
        tbl[13] = mkv(1, 4'hF, 0, 4'h0, 0, 0,  1, 0, 0, 1, 1, 2, 1, 0);
        tbl[14] = mkv(1, 4'hF, 0, 4'h0, 0, 0,  1, 1, 0, 1, 1, 2, 0, 0);
        tbl[15] = mkv(1, 4'hB, 0, 4'h0, 0, 0,  0, 0, 1, 1, 1, 3, 0, 0);
        tbl[16] = mkv(1, 4'hB, 0, 4'h0, 0, 0,  0, 0, 1, 1, 1, 3, 0, 1);
        tbl[17] = mkv(1, 4'hB, 0, 4'h0, 0, 0,  0, 0, 1, 1, 1, 3, 0, 2);
        tbl[18] = mkv(1, 4'hF, 0, 4'h0, 0, 0,  1, 2, 0, 1, 1, 3, 0, 3);
        tbl[19] = mkv(1, 4'hF, 0, 4'h0, 0, 0,  1, 3, 0, 1, 1, 2, 0, 3);
        tbl[20] = mkv(1, 4'hF, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 2, 0, 3);
        tbl[21] = mkv(1, 4'hF, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 2, 0, 3);
        // done mid-push, push_en during push ignored, restart at lowest bit
        tbl[22] = mkv(1, 4'hF, 1, 4'hE, 0, 0,  0, 0, 0, 0, 1, 2, 0, 3);
        tbl[23] = mkv(1, 4'hF, 1, 4'h1, 0, 0,  1, 1, 0, 1, 1, 2, 0, 0);
        tbl[24] = mkv(1, 4'hF, 0, 4'h0, 1, 0,  1, 2, 0, 1, 1, 3, 0, 0);
        tbl[25] = mkv(1, 4'hF, 1, 4'h6, 0, 0,  0, 0, 0, 0, 1, 2, 0, 0);
        tbl[26] = mkv(1, 4'hF, 0, 4'h0, 1, 0,  1, 1, 0, 1, 1, 2, 0, 0);
        tbl[27] = mkv(1, 4'hF, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 2, 0, 0);
        // ready 1100 with instr_ready toggling
        tbl[28] = mkv(1, 4'hC, 0, 4'h0, 0, 1,  0, 0, 0, 0, 1, 2, 2, 0);
        tbl[29] = mkv(1, 4'hC, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 3, 2, 0);
        tbl[30] = mkv(1, 4'hC, 0, 4'h0, 0, 1,  0, 0, 0, 0, 1, 3, 2, 0);
        tbl[31] = mkv(1, 4'hC, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 2, 2, 0);

        #1;
        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].rst_n, tbl[i].rdy, tbl[i].pen, tbl[i].pm, tbl[i].done, tbl[i].ir);
            #1;
            chk($sformatf("v%0d push_valid", i),  pv_a,    tbl[i].e_pv);
            chk($sformatf("v%0d push_warp", i),   pw_a,    tbl[i].e_pw);
            chk($sformatf("v%0d pause", i),       pause_a, tbl[i].e_pause);
            chk($sformatf("v%0d push_active", i), pa_a,    tbl[i].e_pa);
            chk($sformatf("v%0d instr_valid", i), iv_a,    tbl[i].e_iv);
            chk($sformatf("v%0d instr_warp", i),  iw_a,    tbl[i].e_iw);
            chk($sformatf("v%0d fixed_warp", i),  iw_b,    tbl[i].e_fiw);
            chk($sformatf("v%0d stall_cnt", i),   sc_a,    tbl[i].e_sc);
            @(posedge clk);
            #1;
        end

        // Reset mid-push with stall_cnt = 5, then a zero-mask push_en.
        drive(1, 4'h0, 1, 4'hF, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 4'h0, 0, 4'h0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset stall_cnt", sc_a, 5);
        chk("pre_reset pause", pause_a, 1);
        chk("pre_reset push_active", pa_a, 1);
        #2;
        ready_warps = 4'b0100;
        reset_n = 1'b0;
        #1;
        chk("async_reset push_active", pa_a, 0);
        chk("async_reset stall_cnt", sc_a, 0);
        chk("async_reset pause", pause_a, 0);
        chk("async_reset push_valid", pv_a, 0);
        chk("async_reset push_warp", pw_a, 0);
        chk("reset instr_valid", iv_a, 1);
        chk("reset instr_warp", iw_a, 2);
        @(posedge clk);
        #1;
        drive(1, 4'hF, 1, 4'h0, 0, 0);
        @(posedge clk);
        #1;
        push_en = 1'b0;
        chk("zero_mask push_active", pa_a, 0);
        chk("zero_mask push_valid", pv_a, 0);

        // Stall counter saturation.
        drive(1, 4'h0, 1, 4'h1, 0, 0);
        @(posedge clk);
        #1;
        push_en = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("sat stall_cnt", sc_a, 255);
        chk("sat pause", pause_a, 1);
        matmul_done = 1'b1;
        @(posedge clk);
        #1;
        matmul_done = 1'b0;
        chk("sat done push_active", pa_a, 0);

        // Randomized run against the reference model.
        drive(0, 4'h0, 0, 4'h0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mq.delete();
        m_act = 0;
        m_stall = 0;
        m_rr = 0;
        for (int c = 0; c < 3000; c++) begin
            int         cur;
            logic       epv, eps, push;
            logic [3:0] el;
            int         g_rr, g_fx;
            ready_warps = 4'($urandom);
            push_en     = ($urandom_range(0, 5) == 0);
            push_mask   = 4'($urandom);
            matmul_done = ($urandom_range(0, 15) == 0);
            instr_ready = 1'($urandom_range(0, 1));
            #1;
            push = m_act && (mq.size() > 0);
            cur  = push ? mq[0] : 0;
            epv  = push && ready_warps[cur];
            eps  = push && !ready_warps[cur];
            el   = ready_warps & ~(epv ? (4'b0001 << cur) : 4'b0000);
            g_rr = first_from(el, m_rr);
            g_fx = first_from(el, 0);
            chk("rnd push_valid",  pv_a,    epv);
            chk("rnd push_warp",   pw_a,    epv ? cur : 0);
            chk("rnd pause",       pause_a, eps);
            chk("rnd push_active", pa_a,    m_act);
            chk("rnd instr_valid", iv_a,    g_rr >= 0);
            chk("rnd instr_warp",  iw_a,    (g_rr >= 0) ? g_rr : 0);
            chk("rnd fixed_warp",  iw_b,    (g_fx >= 0) ? g_fx : 0);
            chk("rnd stall_cnt",   sc_a,    m_stall);
            @(posedge clk);
            if (g_rr >= 0 && instr_ready) m_rr = (g_rr + 1) % 4;
            if (!m_act) begin
                if (push_en && push_mask != 0) begin
                    mq.delete();
                    for (int i = 0; i < 4; i++) if (push_mask[i]) mq.push_back(i);
                    m_act   = 1;
                    m_stall = 0;
                end
            end else begin
                if (eps && m_stall < 255) m_stall++;
                if (matmul_done) begin
                    m_act = 0;
                    mq.delete();
                end else if (epv) begin
                    void'(mq.pop_front());
                end
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/warp_scheduler.md
# warp_scheduler

- Parametrised successor to the 4-warp selector for the compute unit.
- Each cycle it chooses one warp for the instruction-issue stage, using round-robin or fixed-priority arbitration.
- It also sequences the warps that feed the systolic array during a matmul push.
- It sits between the warp-state table (ready mask), control (push start), the push/pull unit (matmul completion) and the issue stage (valid/ready handshake).

## Interface
- NUM_WARPS, 4: number of warps; must be ≥2.
- WID_W, $clog2(NUM_WARPS): warp-ID width.
- ARB_MODE, 0: 0 = round-robin instruction arbitration; 1 = fixed priority, lowest index wins.
- CNT_W, 8: width of the stall counter.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ready_warps  in  NUM_WARPS  bit i = warp i ready, from warp states.
- push_en  in  1  one-cycle start of a push sequence, from control.
- push_mask  in  NUM_WARPS  warps participating in the push; sampled when push_en = 1.
- matmul_done  in  1  from the push/pull unit; push complete.
- instr_ready  in  1  issue stage accepts instr_warp.
- push_valid  out  1  push_warp is being pushed this cycle.
- push_warp  out  WID_W  warp being pushed; 0 when push_valid = 0.
- pause  out  1  systolic array must stall because the required warp is not ready.
- push_active  out  1  state ≠ IDLE.
- instr_valid  out  1  an eligible warp exists.
- instr_warp  out  WID_W  granted warp; 0 when instr_valid = 0.
- stall_cnt  out  CNT_W  saturating count of pause cycles in the current or last push.

## Operation
- States: IDLE, PUSH, WAIT_DONE.
- IDLE:
  - push_en with push_mask ≠ 0: latch the mask into pmask, set cur = lowest set bit of the mask, clear stall_cnt, go to PUSH.
  - push_en with push_mask = 0: ignored.
- PUSH:
  - The current warp is cur.
  - push_valid = ready_warps[cur]; pause = !ready_warps[cur]; push_warp = cur when valid.
  - On push_valid: cur advances to the next set bit of pmask above cur.
  - If cur is the highest set bit of pmask, go to WAIT_DONE instead.
  - On pause: cur holds, and stall_cnt increments, saturating at all-ones.
- WAIT_DONE: push_valid = 0, pause = 0; waits for matmul_done.
- matmul_done in PUSH or WAIT_DONE: go to IDLE next cycle.
  - This has priority over a push advance in the same cycle; the push beat itself is still presented combinationally that cycle.
- matmul_done in IDLE: ignored.
- push_en while not IDLE: ignored (no restart).
- Instruction arbitration:
  - eligible = ready_warps & ~(push_valid ? onehot(cur) : 0). A warp being pushed cannot issue in the same cycle.
  - ARB_MODE 0: grant the first eligible warp at or above rr_ptr, wrapping modulo NUM_WARPS.
  - ARB_MODE 1: grant the lowest eligible index; rr_ptr is unused.
  - instr_valid = |eligible.
  - On instr_valid & instr_ready: rr_ptr ← (instr_warp + 1) mod NUM_WARPS, wrapping at NUM_WARPS-1 → 0.
  - No handshake: rr_ptr holds.
  - The grant may change while valid and not accepted; the issue stage must not rely on it holding.
- Reset (async, on reset_n low):
  - State registers: state = IDLE, cur = 0, pmask = 0, rr_ptr = 0, stall_cnt = 0.
  - Outputs: push_valid = 0, pause = 0, push_active = 0, push_warp = 0, stall_cnt = 0.
  - instr_valid/instr_warp are combinational from ready_warps and are therefore live during reset.
  - Reset mid-push abandons the sequence immediately.

## Timing
- All outputs are combinational from registered state plus the current ready_warps.
- Zero-cycle latency from a ready change to pause/push_valid/instr_valid.
- push_en at edge k: PUSH is visible in cycle k+1. The first push_valid is no earlier than cycle k+1.
- A mask with m warps all ready: push_valid for m consecutive cycles, then WAIT_DONE.
- matmul_done at edge k: IDLE from cycle k+1, so push_active falls in k+1.
- rr_ptr and cur update only on the clock edge; no combinational loops from instr_ready to instr_warp.

## Structure
- Package warp_sched_pkg: state enum (IDLE, PUSH, WAIT_DONE) and ARB_MODE constants (ARB_RR, ARB_FIXED).
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], ptr[$clog2(N)], mode.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational; the rotate-priority find-first lives here.
- The next-set-bit / lowest-set-bit search over pmask reuses rr_arbiter with mode = fixed and req masked to bits above cur.

## Test plan
- Reset then idle, ready_warps = 4'b1111, instr_ready = 1, ARB_MODE 0 → instr_warp sequence 0, 1, 2, 3, 0; push_active = 0, stall_cnt = 0.
- push_en with push_mask = 4'b1011, all ready → push_warp 0, 1, 3 in consecutive cycles, then WAIT_DONE; instr never grants the warp being pushed that cycle.
- push_mask = 4'b1111 with ready[2] low for 3 cycles while cur = 2 → pause high 3 cycles, cur holds at 2, stall_cnt = 3, then push_warp = 2, 3.
- matmul_done asserted mid-PUSH (after warp 1) → IDLE next cycle; a push_en arriving during PUSH is ignored; a new push_en afterwards restarts at the lowest mask bit.
- ARB_MODE 1, ready = 4'b1100, instr_ready toggling → instr_warp = 2 constantly; rr_ptr does not affect the grant.
- Assert reset_n low mid-PUSH with stall_cnt = 5 → state, counter and push outputs are 0 asynchronously; push_en with push_mask = 0 afterwards stays IDLE.
